alu_req_scheduler: RTL and testbench

Sequencer and arbiter that shares one 4-bit ALU datapath (add/sub/and/or, 4-bit result plus carry/borrow) between two requesters. Each requester hands over one operand pair and opcode through a valid/ready handshake. The block grants requesters round-robin, drives the ALU and waits a configurable number of cycles before sampling it. It returns the result with the requester ID and checks every ALU result against an internal golden model, flagging and counting mismatches.

---
 rtl/alu_req_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_alu_req_scheduler.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_scheduler.sv
// Round-robin scheduler sharing one 4-bit ALU between two requesters.
// Samples the ALU ALU_LAT cycles after issue, checks against a golden model, returns result.
module alu_req_scheduler #(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [3:0] req_a0,
  input  logic [3:0] req_b0,
  input  logic [1:0] req_op0,
  input  logic [3:0] req_a1,
  input  logic [3:0] req_b1,
  input  logic [1:0] req_op1,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_op,
  input  logic [3:0] alu_res,
  input  logic       alu_cout,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [3:0] rsp_res,
  output logic       rsp_cout,
  output logic       rsp_err,
  output logic [7:0] err_cnt,
  output logic       alarm
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [2:0] LAT_LAST = 3'(ALU_LAT - 1);

  state_e     state_q, state_d;
  logic       prio_q, prio_d;
  logic [2:0] lat_q, lat_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [1:0] op_q, op_d;
  logic       id_q, id_d;
  logic [3:0] res_q, res_d;
  logic       cout_q, cout_d;
  logic       err_q, err_d;
  logic [7:0] cnt_q, cnt_d;
  logic       alarm_q, alarm_d;

  logic [1:0] grant;
  logic       accept;
  logic       accept_id;
  logic       sample;
  logic [4:0] golden;
  logic       mismatch;

  // prio_q names the requester that wins when both are valid
  always_comb begin
    grant = '0;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio_q ? 2'b10 : 2'b01;
      default: grant = '0;
    endcase
  end

  assign accept    = |(req_valid & req_ready);
  assign accept_id = req_ready[1];
  assign sample    = (state_q == WAIT) && (lat_q == LAT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = WAIT;
      WAIT:    if (sample)    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // req_ready is forced low while reset is asserted, not just after the clock sees it
  always_comb begin
    req_ready = ((state_q == IDLE) && rst_n) ? grant : '0;
    rsp_valid = (state_q == RESP);
    alu_a     = a_q;
    alu_b     = b_q;
    alu_op    = op_q;
    rsp_id    = id_q;
    rsp_res   = res_q;
    rsp_cout  = cout_q;
    rsp_err   = err_q;
    err_cnt   = cnt_q;
    alarm     = alarm_q;
  end

  always_comb begin
    golden = '0;
    case (op_q)
      2'b00:   golden = {1'b0, a_q} + {1'b0, b_q};
      2'b01:   golden = {1'b0, a_q} - {1'b0, b_q};
      2'b10:   golden = {1'b0, a_q & b_q};
      default: golden = {1'b0, a_q | b_q};
    endcase
  end

  assign mismatch = ({alu_cout, alu_res} != golden);

  always_comb begin
    prio_d  = prio_q;
    lat_d   = lat_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    id_d    = id_q;
    res_d   = res_q;
    cout_d  = cout_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    alarm_d = alarm_q;
    if (accept) begin
      prio_d = ~accept_id;
      lat_d  = '0;
      id_d   = accept_id;
      a_d    = accept_id ? req_a1  : req_a0;
      b_d    = accept_id ? req_b1  : req_b0;
      op_d   = accept_id ? req_op1 : req_op0;
    end else if (state_q == WAIT) begin
      lat_d = lat_q + 3'd1;
    end
    if (sample) begin
      res_d  = alu_res;
      cout_d = alu_cout;
      err_d  = mismatch;
      if (mismatch) begin
        alarm_d = 1'b1;
        if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q  <= 1'b0;
      lat_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      id_q    <= 1'b0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      alarm_q <= 1'b0;
    end else begin
      prio_q  <= prio_d;
      lat_q   <= lat_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      id_q    <= id_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      alarm_q <= alarm_d;
    end
  end

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Directed bench for alu_req_scheduler: one instance at ALU_LAT=1, one at ALU_LAT=3, shared stimulus.
module tb_alu_req_scheduler;

  logic       clk;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [3:0] req_a0, req_b0, req_a1, req_b1;
  logic [1:0] req_op0, req_op1;
  logic       rsp_ready;
  logic       inj_ff, inj_all;

  logic [1:0] rdy1, rdy3;
  logic [3:0] alu_a1, alu_b1, alu_a3, alu_b3;
  logic [1:0] alu_op1, alu_op3;
  logic [3:0] alu_res1, alu_res3;
  logic       alu_cout1, alu_cout3;
  logic       rv1, rv3, rid1, rid3, rcout1, rcout3, rerr1, rerr3, alarm1, alarm3;
  logic [3:0] rres1, rres3;
  logic [7:0] ecnt1, ecnt3;

  int errors = 0;
  int checks = 0;

  alu_req_scheduler #(.ALU_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy1),
    .req_a0(req_a0), .req_b0(req_b0), .req_op0(req_op0),
    .req_a1(req_a1), .req_b1(req_b1), .req_op1(req_op1),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_op(alu_op1),
    .alu_res(alu_res1), .alu_cout(alu_cout1),
    .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_id(rid1), .rsp_res(rres1),
    .rsp_cout(rcout1), .rsp_err(rerr1), .err_cnt(ecnt1), .alarm(alarm1)
  );

  alu_req_scheduler #(.ALU_LAT(3)) u3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy3),
    .req_a0(req_a0), .req_b0(req_b0), .req_op0(req_op0),
    .req_a1(req_a1), .req_b1(req_b1), .req_op1(req_op1),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_op(alu_op3),
    .alu_res(alu_res3), .alu_cout(alu_cout3),
    .rsp_valid(rv3), .rsp_ready(rsp_ready), .rsp_id(rid3), .rsp_res(rres3),
    .rsp_cout(rcout3), .rsp_err(rerr3), .err_cnt(ecnt3), .alarm(alarm3)
  );

  // Stand-in ALU datapath with fault injection hooks
  function automatic logic [4:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic [1:0] op, input logic f_ff,
                                           input logic f_all);
    logic [4:0] r;
    case (op)
      2'b00:   r = {1'b0, a} + {1'b0, b};
      2'b01:   r = {1'b0, a} - {1'b0, b};
      2'b10:   r = {1'b0, a & b};
      default: r = {1'b0, a | b};
    endcase
    if (f_ff && a == 4'hF && b == 4'hF && op == 2'b00) r = 5'h0F;
    if (f_all) r = ~r;
    return r;
  endfunction

  always_comb {alu_cout1, alu_res1} = alu_model(alu_a1, alu_b1, alu_op1, inj_ff, inj_all);
  always_comb {alu_cout3, alu_res3} = alu_model(alu_a3, alu_b3, alu_op3, inj_ff, inj_all);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rsp_ready = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Present a request and wait for its accept edge; returns #1 after that edge
  task automatic issue(input bit sel, input bit id, input logic [3:0] a,
                       input logic [3:0] b, input logic [1:0] op);
    logic [1:0] r;
    bit got;
    got = 1'b0;
    if (id) begin req_a1 = a; req_b1 = b; req_op1 = op; end
    else    begin req_a0 = a; req_b0 = b; req_op0 = op; end
    req_valid[id] = 1'b1;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      r = sel ? rdy3 : rdy1;
      if (r[id]) got = 1'b1;
    end
    chk("accept_seen", {31'd0, got}, 32'd1);
    if (got) begin
      @(posedge clk);
      #1;
    end
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_rsp(input bit sel, output int cyc);
    bit got;
    got = 1'b0;
    cyc = 0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      cyc++;
      if (sel ? rv3 : rv1) got = 1'b1;
    end
    chk("rsp_seen", {31'd0, got}, 32'd1);
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  typedef struct packed {
    logic       id;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic [3:0] res;
    logic       cout;
    logic       err;
    logic [7:0] cnt;
    logic       alarm;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int cyc;
    int nrsp;
    int bad;
    int rcyc [4];
    logic       rid  [4];
    logic [3:0] rres [4];
    logic       rco  [4];
    logic [7:0] exp_cnt;

    //          id    a      b      op     res    co    err   cnt    alarm
    tbl[0] = '{1'b0, 4'h3, 4'h5, 2'b01, 4'hE, 1'b1, 1'b0, 8'd0, 1'b0};
    tbl[1] = '{1'b1, 4'h7, 4'h9, 2'b00, 4'h0, 1'b1, 1'b0, 8'd0, 1'b0};
    tbl[2] = '{1'b0, 4'hA, 4'hC, 2'b10, 4'h8, 1'b0, 1'b0, 8'd0, 1'b0};
    tbl[3] = '{1'b1, 4'h5, 4'hA, 2'b11, 4'hF, 1'b0, 1'b0, 8'd0, 1'b0};
    tbl[4] = '{1'b0, 4'hF, 4'hF, 2'b00, 4'hF, 1'b0, 1'b1, 8'd1, 1'b1};
    tbl[5] = '{1'b1, 4'h2, 4'h2, 2'b00, 4'h4, 1'b0, 1'b0, 8'd1, 1'b1};
    tbl[6] = '{1'b0, 4'h0, 4'h1, 2'b01, 4'hF, 1'b1, 1'b0, 8'd1, 1'b1};
    tbl[7] = '{1'b1, 4'h8, 4'h8, 2'b01, 4'h0, 1'b0, 1'b0, 8'd1, 1'b1};

    req_valid = 2'b00;
    req_a0 = '0; req_b0 = '0; req_op0 = '0;
    req_a1 = '0; req_b1 = '0; req_op1 = '0;
    rsp_ready = 1'b0;
    inj_ff = 1'b0;
    inj_all = 1'b0;

    // Reset values, with both requests valid to expose req_ready gating
    rst_n = 1'b0;
    req_valid = 2'b11;
    #3;
    chk("rst_req_ready", {30'd0, rdy1}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rv1}, 32'd0);
    chk("rst_rsp_fields", {22'd0, rid1, rres1, rcout1, rerr1, alarm1, 2'b00}, 32'd0);
    chk("rst_alu", {22'd0, alu_a1, alu_b1, alu_op1}, 32'd0);
    chk("rst_err_cnt", {24'd0, ecnt1}, 32'd0);
    req_valid = 2'b00;
    do_reset();

    // Table of single operations on the ALU_LAT=1 instance
    inj_ff = 1'b1;
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].op);
      wait_rsp(1'b0, cyc);
      chk($sformatf("v%0d_latency", i), cyc, 32'd2);
      chk($sformatf("v%0d_id", i), {31'd0, rid1}, {31'd0, tbl[i].id});
      chk($sformatf("v%0d_res", i), {28'd0, rres1}, {28'd0, tbl[i].res});
      chk($sformatf("v%0d_cout", i), {31'd0, rcout1}, {31'd0, tbl[i].cout});
      chk($sformatf("v%0d_err", i), {31'd0, rerr1}, {31'd0, tbl[i].err});
      chk($sformatf("v%0d_err_cnt", i), {24'd0, ecnt1}, {24'd0, tbl[i].cnt});
      chk($sformatf("v%0d_alarm", i), {31'd0, alarm1}, {31'd0, tbl[i].alarm});
      handshake();
    end
    inj_ff = 1'b0;

    // Both requesters continuously valid, rsp_ready tied high
    do_reset();
    req_a0 = 4'h1; req_b0 = 4'h2; req_op0 = 2'b00;
    req_a1 = 4'h9; req_b1 = 4'h6; req_op1 = 2'b11;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    nrsp = 0;
    for (int n = 0; n < 60 && nrsp < 4; n++) begin
      @(negedge clk);
      if (rv1) begin
        rcyc[nrsp] = n;
        rid[nrsp]  = rid1;
        rres[nrsp] = rres1;
        rco[nrsp]  = rcout1;
        nrsp++;
      end
    end
    chk("rr_count", nrsp, 32'd4);
    for (int i = 0; i < nrsp; i++) begin
      chk($sformatf("rr%0d_id", i), {31'd0, rid[i]}, (i % 2 == 0) ? 32'd0 : 32'd1);
      chk($sformatf("rr%0d_res", i), {28'd0, rres[i]}, (i % 2 == 0) ? 32'h3 : 32'hF);
      chk($sformatf("rr%0d_cout", i), {31'd0, rco[i]}, 32'd0);
      if (i > 0) chk($sformatf("rr%0d_period", i), rcyc[i] - rcyc[i-1], 32'd3);
    end
    req_valid = 2'b00;
    rsp_ready = 1'b0;

    // Backpressure on the ALU_LAT=3 instance
    do_reset();
    issue(1'b1, 1'b1, 4'h6, 4'h3, 2'b00);
    req_a1 = 4'h4; req_b1 = 4'hC; req_op1 = 2'b10;
    req_valid[1] = 1'b1;
    wait_rsp(1'b1, cyc);
    chk("bp_latency", cyc, 32'd4);
    bad = 0;
    for (int n = 0; n < 10; n++) begin
      if (n > 0) @(negedge clk);
      if (!rv3 || rid3 !== 1'b1 || rres3 !== 4'h9 || rcout3 !== 1'b0 || rerr3 !== 1'b0) bad++;
      if (rdy3 !== 2'b00) bad++;
    end
    chk("bp_hold_violations", bad, 32'd0);
    handshake();
    @(negedge clk);
    chk("bp_rsp_dropped", {31'd0, rv3}, 32'd0);
    chk("bp_ready_after", {30'd0, rdy3}, 32'd2);
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    chk("bp_next_alu", {26'd0, alu_a3, alu_op3}, {26'd0, 4'h4, 2'b10});
    wait_rsp(1'b1, cyc);
    chk("bp2_latency", cyc, 32'd4);
    chk("bp2_res", {27'd0, rid3, rres3}, {27'd0, 1'b1, 4'h4});
    handshake();

    // Reset asserted during WAIT on the ALU_LAT=3 instance
    do_reset();
    inj_ff = 1'b1;
    issue(1'b1, 1'b0, 4'hF, 4'hF, 2'b00);
    wait_rsp(1'b1, cyc);
    chk("pre_rst_cnt", {23'd0, ecnt3, alarm3}, {23'd0, 8'd1, 1'b1});
    handshake();
    inj_ff = 1'b0;
    issue(1'b1, 1'b0, 4'h1, 4'h1, 2'b00);
    @(posedge clk);
    #2;
    req_a1 = 4'h2; req_b1 = 4'h3; req_op1 = 2'b00;
    req_valid = 2'b11;
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", {30'd0, rdy3}, 32'd0);
    chk("mid_rst_rsp", {23'd0, rv3, rid3, rres3, rcout3, rerr3, alarm3}, 32'd0);
    chk("mid_rst_alu", {22'd0, alu_a3, alu_b3, alu_op3}, 32'd0);
    chk("mid_rst_cnt", {24'd0, ecnt3}, 32'd0);
    bad = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (rv3 !== 1'b0 || rdy3 !== 2'b00) bad++;
    end
    chk("rst_hold_quiet", bad, 32'd0);
    rst_n = 1'b1;
    wait_rsp(1'b1, cyc);
    chk("post_rst_first_id", {27'd0, rid3, rres3}, {27'd0, 1'b0, 4'h2});
    req_valid = 2'b00;
    handshake();

    // Saturation: every ALU result corrupted on the ALU_LAT=1 instance
    do_reset();
    inj_all = 1'b1;
    req_a0 = 4'h3; req_b0 = 4'h4; req_op0 = 2'b00;
    req_valid = 2'b01;
    rsp_ready = 1'b1;
    nrsp = 0;
    bad = 0;
    for (int n = 0; n < 2000 && nrsp < 300; n++) begin
      @(negedge clk);
      if (rv1) begin
        nrsp++;
        exp_cnt = (nrsp > 255) ? 8'd255 : 8'(nrsp);
        if (ecnt1 !== exp_cnt || alarm1 !== 1'b1 || rerr1 !== 1'b1) bad++;
      end
    end
    chk("sat_responses", nrsp, 32'd300);
    chk("sat_track_violations", bad, 32'd0);
    chk("sat_final_cnt", {24'd0, ecnt1}, 32'd255);
    chk("sat_final_alarm", {31'd0, alarm1}, 32'd1);
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    inj_all = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
